opicorv32_memif_split: RTL
==========================

OPICORV32_MEMIF_SPLIT -- requirements
Module: opicorv32_memif_split

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of reg_op1, next_pc and mem_addr; address arithmetic wraps modulo 2^ADDR_W.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1: 1 = split misaligned data accesses into two bus beats; 0 = reject them.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_do_rinst, mem_do_prefetch, mem_do_rdata, mem_do_wdata  in  1 each  core requests: fetch, prefetch, load, store.
REQ-006 mem_wordsize  in  2  0 = word, 1 = half, 2/3 = byte; mem_signed  in  1  sign-extend loads.
REQ-007 reg_op1  in  ADDR_W  data address; reg_op2  in  32  store data; next_pc  in  ADDR_W  fetch address.
REQ-008 mem_ready  in  1; mem_rdata  in  32  bus read data.
REQ-009 mem_valid, mem_instr  out  1; mem_addr  out  ADDR_W; mem_wdata  out  32; mem_wstrb  out  4: bus request, all registered.
REQ-010 mem_done  out  1  request complete, combinational; mem_misaligned  out  1  reject flag, combinational.
REQ-011 mem_rdata_word  out  32  aligned, extended load result, combinational; mem_rdata_q  out  32  last accepted bus word, registered.

Function
REQ-012 States: IDLE=0, READ=1, WRITE=2, PFWAIT=3, READ2=4, WRITE2=5; a beat is accepted on a cycle with mem_valid & mem_ready.
REQ-013 Offset off = reg_op1[1:0]; a data access is misaligned when the word size is word and off != 0, or half and off = 3; byte accesses and fetches are never misaligned.
REQ-014 IDLE with a request: at the next edge mem_valid = 1; fetch/prefetch has priority over load; store wins over both.
REQ-015 Fetch: mem_addr = next_pc with bits [1:0] forced to 0, mem_instr = 1, mem_wstrb = 0, next state READ.
REQ-016 Load: mem_addr = reg_op1 with bits [1:0] forced to 0, mem_instr = 0, mem_wstrb = 0, next state READ.
REQ-017 Store: 64-bit lane vector S = reg_op2 (size-masked, zero-extended) << 8*off; byte mask M = (1111/0011/0001 by size) << off.
REQ-018 Store first beat: mem_wdata = S[31:0], mem_wstrb = M[3:0]; lanes not enabled are zero; next state WRITE.
REQ-019 Misaligned first beat accepted: mem_addr += 4, mem_valid stays 1, rdata_lo <= mem_rdata, next state READ2 or WRITE2; store second beat drives mem_wdata = S[63:32], mem_wstrb = M[7:4].
REQ-020 Final beat accepted: mem_valid <= 0, mem_wstrb <= 0, next state IDLE; exception: a prefetch-only fetch goes to PFWAIT instead of IDLE.
REQ-021 mem_done = mem_ready & mem_valid on a final beat of READ, READ2, WRITE or WRITE2, excluding prefetch-only fetches; in PFWAIT, mem_done = mem_do_rinst, which also returns the block to IDLE.
REQ-022 mem_rdata_word: V = {mem_rdata, rdata_lo} in READ2, else {32'b0, mem_rdata}; take (V >> 8*off) truncated to the word size, zero-extended, or sign-extended when mem_signed = 1.
REQ-023 mem_rdata_q <= mem_rdata on every accepted beat.
REQ-024 If ALLOW_MISALIGNED = 0 and IDLE holds a misaligned load/store: mem_misaligned = 1 every such cycle, no bus beat, mem_done = 0, state stays IDLE.
REQ-025 If ALLOW_MISALIGNED = 1, mem_misaligned is constant 0.
REQ-026 Request inputs are ignored outside IDLE and PFWAIT; the bus outputs hold stable while mem_valid & !mem_ready.
REQ-027 Address wrap: a second beat at 2^ADDR_W-4+off wraps mem_addr to 0.

Reset
REQ-028 While reset = 1: state = IDLE and mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_rdata_q and rdata_lo are all 0, asynchronously and mid-transaction included.
REQ-029 After reset is released, no bus beat starts until a request is sampled in IDLE.

Verification
REQ-030 Store, word, reg_op1 = 0x1002, reg_op2 = 0xAABBCCDD -> beat 1: addr 0x1000, wdata 0xCCDD0000, wstrb 1100; beat 2: addr 0x1004, wdata 0x0000AABB, wstrb 0011; mem_done only on beat 2.
REQ-031 Signed half load at 0x2003, rdata 0x80112233 then 0x445566FF -> second-beat cycle: mem_rdata_word = 0xFFFFFF80, mem_done = 1.
REQ-032 Byte loads, aligned: 0x3001 unsigned, rdata 0x12345678 -> 0x00000056; 0x3003 signed, rdata 0x9A000000 -> 0xFFFFFF9A; single beat each.
REQ-033 Prefetch only, ready after 2 wait cycles -> mem_done = 0, state PFWAIT; later mem_do_rinst = 1 -> mem_done = 1 that cycle, then IDLE.
REQ-034 Reset asserted during READ2 with mem_valid = 1 -> mem_valid = 0 before the next edge; all outputs at their reset values.
REQ-035 ALLOW_MISALIGNED = 0, word load at 0x4001 -> mem_misaligned = 1, mem_valid stays 0 for 5 cycles; mem_addr 0xFFFFFFFE split with ALLOW_MISALIGNED = 1 -> second beat at 0x00000000.

Source files
------------

// File: rtl/opicorv32_memif_split.sv
// Memory interface for the picorv32-style core: fetch, prefetch, load and store
// on a valid/ready bus, splitting misaligned data accesses into two beats.
module opicorv32_memif_split #(
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_do_rinst,
  input  logic              mem_do_prefetch,
  input  logic              mem_do_rdata,
  input  logic              mem_do_wdata,
  input  logic [1:0]        mem_wordsize,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] reg_op1,
  input  logic [31:0]       reg_op2,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              mem_done,
  output logic              mem_misaligned,
  output logic [31:0]       mem_rdata_word,
  output logic [31:0]       mem_rdata_q
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    PFWAIT = 3'd3,
    READ2  = 3'd4,
    WRITE2 = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam bit                ALLOW      = (ALLOW_MISALIGNED != 0);

  state_t      state;
  logic [31:0] rdata_lo;
  logic [31:0] wdata_hi;
  logic [3:0]  wstrb_hi;
  logic        split;
  logic        pf_only;

  logic [1:0]  off;
  logic        req_any, is_store, is_fetch, is_data, misal, reject, start, beat;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [63:0] st_lanes;
  logic [7:0]  st_bytes;
  logic [63:0] rd_v;
  logic [31:0] rd_sh;

  assign off      = reg_op1[1:0];
  assign req_any  = mem_do_rinst | mem_do_prefetch | mem_do_rdata | mem_do_wdata;
  assign is_store = mem_do_wdata;
  assign is_fetch = !mem_do_wdata && (mem_do_rinst || mem_do_prefetch);
  assign is_data  = is_store || (!is_fetch && mem_do_rdata);
  assign misal    = is_data && (((mem_wordsize == 2'd0) && (off != 2'd0)) ||
                                ((mem_wordsize == 2'd1) && (off == 2'd3)));
  assign reject   = misal && !ALLOW;
  assign start    = (state == IDLE) && req_any && !reject;
  assign beat     = mem_valid && mem_ready;

  assign mem_misaligned = (state == IDLE) && reject;

  always_comb begin
    case (mem_wordsize)
      2'd0:    begin st_data = reg_op2;                st_mask = 4'b1111; end
      2'd1:    begin st_data = {16'b0, reg_op2[15:0]}; st_mask = 4'b0011; end
      default: begin st_data = {24'b0, reg_op2[7:0]};  st_mask = 4'b0001; end
    endcase
    st_lanes = {32'b0, st_data} << {off, 3'b000};
    st_bytes = {4'b0, st_mask} << off;
  end

  // Second beat of a split load supplies the upper bytes; shift the pair down by the offset.
  always_comb begin
    rd_v  = (state == READ2) ? {mem_rdata, rdata_lo} : {32'b0, mem_rdata};
    rd_sh = 32'(rd_v >> {off, 3'b000});
    case (mem_wordsize)
      2'd0:    mem_rdata_word = rd_sh;
      2'd1:    mem_rdata_word = {{16{mem_signed & rd_sh[15]}}, rd_sh[15:0]};
      default: mem_rdata_word = {{24{mem_signed & rd_sh[7]}}, rd_sh[7:0]};
    endcase
  end

  always_comb begin
    mem_done = 1'b0;
    case (state)
      READ, WRITE:   mem_done = beat && !split && !pf_only;
      READ2, WRITE2: mem_done = beat;
      PFWAIT:        mem_done = mem_do_rinst;
      default:       mem_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      mem_rdata_q <= '0;
      rdata_lo    <= '0;
      wdata_hi    <= '0;
      wstrb_hi    <= '0;
      split       <= 1'b0;
      pf_only     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_valid <= 1'b1;
            mem_instr <= is_fetch;
            mem_addr  <= is_fetch ? (next_pc & ALIGN_MASK) : (reg_op1 & ALIGN_MASK);
            mem_wdata <= is_store ? st_lanes[31:0] : '0;
            mem_wstrb <= is_store ? st_bytes[3:0] : '0;
            wdata_hi  <= is_store ? st_lanes[63:32] : '0;
            wstrb_hi  <= is_store ? st_bytes[7:4] : '0;
            split     <= misal;
            pf_only   <= is_fetch && !mem_do_rinst;
            state     <= is_store ? WRITE : READ;
          end
        end
        READ, WRITE: begin
          if (beat) begin
            mem_rdata_q <= mem_rdata;
            if (split) begin
              mem_addr  <= mem_addr + ADDR_W'(4);
              rdata_lo  <= mem_rdata;
              mem_wdata <= wdata_hi;
              mem_wstrb <= wstrb_hi;
              state     <= (state == READ) ? READ2 : WRITE2;
            end else begin
              mem_valid <= 1'b0;
              mem_wstrb <= '0;
              state     <= pf_only ? PFWAIT : IDLE;
            end
          end
        end
        READ2, WRITE2: begin
          if (beat) begin
            mem_rdata_q <= mem_rdata;
            mem_valid   <= 1'b0;
            mem_wstrb   <= '0;
            state       <= IDLE;
          end
        end
        PFWAIT: begin
          if (mem_do_rinst) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
